// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle controller.
// Holds opcode/funct7 constants, ALU control codes, the FSM state and
// instruction-class enums, trap cause codes and the opcode classifier.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  // Native width of the ALU control codes below.
  localparam int CC_W = 4;

  localparam logic [CC_W-1:0] CC_AND  = 4'b0000;
  localparam logic [CC_W-1:0] CC_OR   = 4'b0001;
  localparam logic [CC_W-1:0] CC_ADD  = 4'b0010;
  localparam logic [CC_W-1:0] CC_XOR  = 4'b0011;
  localparam logic [CC_W-1:0] CC_SLL  = 4'b0100;
  localparam logic [CC_W-1:0] CC_SRL  = 4'b0101;
  localparam logic [CC_W-1:0] CC_SUB  = 4'b0110;
  localparam logic [CC_W-1:0] CC_SLT  = 4'b0111;
  localparam logic [CC_W-1:0] CC_SRA  = 4'b1000;
  localparam logic [CC_W-1:0] CC_SLTU = 4'b1001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE
  } instr_class_t;

  typedef enum logic [1:0] {
    TRAP_NONE   = 2'b00,
    TRAP_OPCODE = 2'b01,
    TRAP_FUNCT  = 2'b10,
    TRAP_MEM    = 2'b11
  } trap_cause_t;

  // CLS_NONE marks an unsupported opcode.
  function automatic instr_class_t classify(input logic [6:0] op);
    case (op)
      OP_R:     return CLS_R;
      OP_I:     return CLS_I;
      OP_LOAD:  return CLS_LOAD;
      OP_STORE: return CLS_STORE;
      default:  return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_cc_decode.sv
// Combinational ALU control decode.
// Ports:
//   cls           in  instruction class derived from the opcode
//   funct7        in  instr[31:25]
//   funct3        in  instr[14:12]
//   alu_cc        out ALU operation code for EXECUTE/WRITEBACK
//   funct_illegal out funct7/funct3 combination not supported for this class
module alu_cc_decode
  import rv_ctrl_pkg::*;
(
  input  instr_class_t    cls,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  output logic [CC_W-1:0] alu_cc,
  output logic            funct_illegal
);

  logic shift_op;
  logic f7_checked;
  logic f7_alt;

  assign shift_op   = (funct3 == 3'b001) || (funct3 == 3'b101);
  // For I-ALU, funct7 only carries meaning on shifts; elsewhere it is immediate bits.
  assign f7_checked = (cls == CLS_R) || ((cls == CLS_I) && shift_op);
  assign f7_alt     = (funct7 == F7_ALT);

  always_comb begin
    funct_illegal = 1'b0;
    if (f7_checked) begin
      if ((funct7 != F7_BASE) && !f7_alt)
        funct_illegal = 1'b1;
      else if (f7_alt && (funct3 != 3'b000) && (funct3 != 3'b101))
        funct_illegal = 1'b1;
    end
  end

  always_comb begin
    alu_cc = CC_ADD;
    if ((cls == CLS_R) || (cls == CLS_I)) begin
      case (funct3)
        3'b000:  alu_cc = ((cls == CLS_R) && f7_alt) ? CC_SUB : CC_ADD;
        3'b001:  alu_cc = CC_SLL;
        3'b010:  alu_cc = CC_SLT;
        3'b011:  alu_cc = CC_SLTU;
        3'b100:  alu_cc = CC_XOR;
        3'b101:  alu_cc = f7_alt ? CC_SRA : CC_SRL;
        3'b110:  alu_cc = CC_OR;
        default: alu_cc = CC_AND;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I datapath: sequences one instruction
// at a time and drives the datapath strobes, waits on data memory with a
// timeout, traps on illegal encodings and counts retired instructions.
//
// state     | meaning
// IDLE      | stopped at an instruction boundary, waiting for run
// FETCH     | load instruction register
// DECODE    | classify opcode, latch class and alu_cc, trap if illegal
// EXECUTE   | ALU operation
// MEMORY    | load/store, waiting for mem_ready (bounded by MEM_TIMEOUT)
// WRITEBACK | register write, PC advance, retire
// TRAP      | halted on illegal instruction or memory timeout; reset only
//
// Ports:
//   clk, reset (async, active-low), run
//   opcode/funct7/funct3 from the datapath, mem_ready from data memory
//   pc_en, ir_en, reg_write, mem2reg, alu_src, mem_write, mem_read, alu_cc
//   busy, illegal (sticky), trap_cause, retired (wrapping count)
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int ALU_CC_W    = 4,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [6:0]          opcode,
  input  logic [6:0]          funct7,
  input  logic [2:0]          funct3,
  input  logic                mem_ready,
  output logic                pc_en,
  output logic                ir_en,
  output logic                reg_write,
  output logic                mem2reg,
  output logic                alu_src,
  output logic                mem_write,
  output logic                mem_read,
  output logic [ALU_CC_W-1:0] alu_cc,
  output logic                busy,
  output logic                illegal,
  output logic [1:0]          trap_cause,
  output logic [CNT_W-1:0]    retired
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t          state_q, state_d;
  instr_class_t    dec_cls, cls_q;
  logic [CC_W-1:0] dec_cc, cc_q, cc_out;
  logic            dec_funct_illegal;
  logic [WAIT_W-1:0] wait_q;
  trap_cause_t     cause_q, cause_d;
  logic            illegal_q;
  logic            is_load, is_store;
  logic            mem_timeout;
  logic            retire;

  assign dec_cls = classify(opcode);

  alu_cc_decode u_alu_cc_decode (
    .cls           (dec_cls),
    .funct7        (funct7),
    .funct3        (funct3),
    .alu_cc        (dec_cc),
    .funct_illegal (dec_funct_illegal)
  );

  assign is_load  = (cls_q == CLS_LOAD);
  assign is_store = (cls_q == CLS_STORE);

  // Last allowed MEMORY cycle without ready; a ready in this cycle still wins.
  assign mem_timeout = !mem_ready && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  assign retire = (state_q == ST_WRITEBACK) ||
                  ((state_q == ST_MEMORY) && is_store && mem_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE:    if (run) state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_DECODE;
      ST_DECODE: begin
        if (dec_cls == CLS_NONE) begin
          state_d = ST_TRAP;
          cause_d = TRAP_OPCODE;
        end else if (dec_funct_illegal) begin
          state_d = ST_TRAP;
          cause_d = TRAP_FUNCT;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: state_d = (is_load || is_store) ? ST_MEMORY : ST_WRITEBACK;
      ST_MEMORY: begin
        if (mem_ready) begin
          if (is_load) state_d = ST_WRITEBACK;
          else         state_d = run ? ST_FETCH : ST_IDLE;
        end else if (mem_timeout) begin
          state_d = ST_TRAP;
          cause_d = TRAP_MEM;
        end
      end
      ST_WRITEBACK: state_d = run ? ST_FETCH : ST_IDLE;
      ST_TRAP:      state_d = ST_TRAP;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_en     = 1'b0;
    ir_en     = 1'b0;
    reg_write = 1'b0;
    mem2reg   = 1'b0;
    alu_src   = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    cc_out    = '0;
    case (state_q)
      ST_FETCH: ir_en = 1'b1;
      ST_EXECUTE: begin
        cc_out  = cc_q;
        alu_src = (cls_q != CLS_R);
      end
      ST_MEMORY: begin
        cc_out    = CC_ADD;
        alu_src   = 1'b1;
        mem_read  = is_load;
        mem_write = is_store;
        // Stores retire straight out of MEMORY, so the PC advances on ready.
        pc_en     = is_store && mem_ready;
      end
      ST_WRITEBACK: begin
        reg_write = 1'b1;
        mem2reg   = is_load;
        pc_en     = 1'b1;
        cc_out    = cc_q;
        alu_src   = (cls_q != CLS_R);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cls_q     <= CLS_NONE;
      cc_q      <= '0;
      wait_q    <= '0;
      cause_q   <= TRAP_NONE;
      illegal_q <= 1'b0;
      retired   <= '0;
    end else begin
      cause_q <= cause_d;
      if (state_d == ST_TRAP) illegal_q <= 1'b1;
      if (state_q == ST_DECODE) begin
        cls_q <= dec_cls;
        cc_q  <= dec_cc;
      end
      if (state_q == ST_EXECUTE)
        wait_q <= '0;
      else if ((state_q == ST_MEMORY) && !mem_ready)
        wait_q <= wait_q + 1'b1;
      if (retire) retired <= retired + 1'b1;
    end
  end

  assign alu_cc     = ALU_CC_W'(cc_out);
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_TRAP);
  assign illegal    = illegal_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. A second instance with a 3-bit
// retire counter shares all inputs so that counter wrap is exercised.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset, run, mem_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  logic pc_en, ir_en, reg_write, mem2reg, alu_src, mem_write, mem_read, busy, illegal;
  logic [3:0] alu_cc;
  logic [1:0] trap_cause;
  logic [15:0] retired;

  logic s_pc_en, s_ir_en, s_reg_write, s_mem2reg, s_alu_src, s_mem_write, s_mem_read, s_busy, s_illegal;
  logic [3:0] s_alu_cc;
  logic [1:0] s_trap_cause;
  logic [2:0] s_retired;

  int checks = 0;
  int errors = 0;
  int model_retired = 0;

  localparam int B_NONE = -1, B_R = 0, B_I = 1, B_LOAD = 2, B_STORE = 3;

  always #5 clk = ~clk;

  multicycle_ctrl #(.ALU_CC_W(4), .CNT_W(16), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct7(funct7), .funct3(funct3),
    .mem_ready(mem_ready), .pc_en(pc_en), .ir_en(ir_en), .reg_write(reg_write),
    .mem2reg(mem2reg), .alu_src(alu_src), .mem_write(mem_write), .mem_read(mem_read),
    .alu_cc(alu_cc), .busy(busy), .illegal(illegal), .trap_cause(trap_cause), .retired(retired)
  );

  multicycle_ctrl #(.ALU_CC_W(4), .CNT_W(3), .MEM_TIMEOUT(15)) dut_small (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct7(funct7), .funct3(funct3),
    .mem_ready(mem_ready), .pc_en(s_pc_en), .ir_en(s_ir_en), .reg_write(s_reg_write),
    .mem2reg(s_mem2reg), .alu_src(s_alu_src), .mem_write(s_mem_write), .mem_read(s_mem_read),
    .alu_cc(s_alu_cc), .busy(s_busy), .illegal(s_illegal), .trap_cause(s_trap_cause),
    .retired(s_retired)
  );

  // Reference model: instruction semantics straight from the ISA tables.
  function automatic int m_class(input logic [6:0] op);
    case (op)
      7'b0110011: return B_R;
      7'b0010011: return B_I;
      7'b0000011: return B_LOAD;
      7'b0100011: return B_STORE;
      default:    return B_NONE;
    endcase
  endfunction

  function automatic int m_cause(input int cls, input logic [6:0] f7, input logic [2:0] f3);
    bit needs_f7;
    if (cls == B_NONE) return 1;
    needs_f7 = (cls == B_R) || (cls == B_I && (f3 == 3'd1 || f3 == 3'd5));
    if (needs_f7) begin
      if (!(f7 == 7'h00 || f7 == 7'h20)) return 2;
      if (f7 == 7'h20 && !(f3 == 3'd0 || f3 == 3'd5)) return 2;
    end
    return 0;
  endfunction

  function automatic logic [3:0] m_cc(input int cls, input logic [6:0] f7, input logic [2:0] f3);
    if (cls == B_LOAD || cls == B_STORE) return 4'd2;
    case (f3)
      3'd0: return (cls == B_R && f7 == 7'h20) ? 4'd6 : 4'd2;
      3'd1: return 4'd4;
      3'd2: return 4'd7;
      3'd3: return 4'd9;
      3'd4: return 4'd3;
      3'd5: return (f7 == 7'h20) ? 4'd8 : 4'd5;
      3'd6: return 4'd1;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [12:0] mk(input bit pc, ir, rw, m2r, src, mw, mr, bsy, ill,
                                     input logic [3:0] cc);
    return {pc, ir, rw, m2r, src, mw, mr, bsy, ill, cc};
  endfunction

  function automatic logic [25:0] obs();
    return {pc_en, ir_en, reg_write, mem2reg, alu_src, mem_write, mem_read, busy, illegal, alu_cc,
            s_pc_en, s_ir_en, s_reg_write, s_mem2reg, s_alu_src, s_mem_write, s_mem_read,
            s_busy, s_illegal, s_alu_cc};
  endfunction

  function automatic logic [18:0] obs_cnt();
    return {retired, s_retired};
  endfunction

  function automatic logic [18:0] exp_cnt();
    return {16'(model_retired), 3'(model_retired)};
  endfunction

  // Drive one instruction from its FETCH cycle to completion and compare every cycle.
  task automatic issue(input string tag, input logic [6:0] op, input logic [6:0] f7,
                       input logic [2:0] f3, input int wait_n, input bit drop_run,
                       output bit trapped);
    int cls, cause;
    logic [3:0] cc;
    logic [12:0] e;
    bit rdy, done;
    cls = m_class(op);
    cause = m_cause(cls, f7, f3);
    cc = m_cc(cls, f7, f3);
    trapped = 1'b0;

    @(negedge clk);
    opcode = op; funct7 = f7; funct3 = f3; mem_ready = 1'($urandom_range(1));
    #1;
    e = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 4'd0);
    checks++;
    if (obs() !== {e, e}) begin errors++; $display("FAIL %s fetch: got %h want %h", tag, obs(), {e, e}); end
    checks++;
    if (obs_cnt() !== exp_cnt()) begin errors++; $display("FAIL %s retired_fetch: got %h want %h", tag, obs_cnt(), exp_cnt()); end

    @(negedge clk); mem_ready = 1'($urandom_range(1)); #1;
    e = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
    checks++;
    if (obs() !== {e, e}) begin errors++; $display("FAIL %s decode: got %h want %h", tag, obs(), {e, e}); end

    if (cause != 0) begin
      for (int t = 0; t < 2; t++) begin
        @(negedge clk); #1;
        e = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0);
        checks++;
        if (obs() !== {e, e}) begin errors++; $display("FAIL %s trap: got %h want %h", tag, obs(), {e, e}); end
        checks++;
        if ({trap_cause, s_trap_cause} !== {2'(cause), 2'(cause)})
          begin errors++; $display("FAIL %s trap_cause: got %b want %0d", tag, {trap_cause, s_trap_cause}, cause); end
        checks++;
        if (obs_cnt() !== exp_cnt()) begin errors++; $display("FAIL %s retired_trap: got %h want %h", tag, obs_cnt(), exp_cnt()); end
      end
      trapped = 1'b1;
      return;
    end

    @(negedge clk); mem_ready = 1'($urandom_range(1));
    if (drop_run) run = 1'b0;
    #1;
    e = mk(0, 0, 0, 0, cls != B_R, 0, 0, 1, 0, cc);
    checks++;
    if (obs() !== {e, e}) begin errors++; $display("FAIL %s execute: got %h want %h", tag, obs(), {e, e}); end

    done = 1'b0;
    if (cls == B_LOAD || cls == B_STORE) begin
      rdy = 1'b0;
      for (int k = 1; k <= 15; k++) begin
        @(negedge clk);
        rdy = (k == wait_n + 1);
        mem_ready = rdy;
        #1;
        e = mk(cls == B_STORE && rdy, 0, 0, 0, 1, cls == B_STORE, cls == B_LOAD, 1, 0, 4'd2);
        checks++;
        if (obs() !== {e, e}) begin errors++; $display("FAIL %s memory%0d: got %h want %h", tag, k, obs(), {e, e}); end
        if (rdy) break;
      end
      if (!rdy) begin
        @(negedge clk); mem_ready = 1'($urandom_range(1)); #1;
        e = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0);
        checks++;
        if (obs() !== {e, e}) begin errors++; $display("FAIL %s timeout_trap: got %h want %h", tag, obs(), {e, e}); end
        checks++;
        if ({trap_cause, s_trap_cause} !== 4'b1111)
          begin errors++; $display("FAIL %s timeout_cause: got %b want 1111", tag, {trap_cause, s_trap_cause}); end
        checks++;
        if (obs_cnt() !== exp_cnt()) begin errors++; $display("FAIL %s retired_timeout: got %h want %h", tag, obs_cnt(), exp_cnt()); end
        trapped = 1'b1;
        return;
      end
      if (cls == B_STORE) begin
        model_retired++;
        done = 1'b1;
      end
    end

    if (!done) begin
      @(negedge clk); mem_ready = 1'($urandom_range(1)); #1;
      e = mk(1, 0, 1, cls == B_LOAD, cls != B_R, 0, 0, 1, 0, cc);
      checks++;
      if (obs() !== {e, e}) begin errors++; $display("FAIL %s writeback: got %h want %h", tag, obs(), {e, e}); end
      model_retired++;
    end

    if (!run) begin
      @(negedge clk); #1;
      e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
      checks++;
      if (obs() !== {e, e}) begin errors++; $display("FAIL %s idle_stop: got %h want %h", tag, obs(), {e, e}); end
      checks++;
      if (obs_cnt() !== exp_cnt()) begin errors++; $display("FAIL %s retired_idle: got %h want %h", tag, obs_cnt(), exp_cnt()); end
      run = 1'b1;
    end
  endtask

  // Leaves the DUT in IDLE with run=1, so the next posedge enters FETCH.
  task automatic test_reset(input string tag);
    logic [12:0] z;
    z = '0;
    @(negedge clk);
    reset = 1'b0; run = 1'b0; mem_ready = 1'b1;
    opcode = 7'($urandom); funct7 = 7'($urandom); funct3 = 3'($urandom);
    #1;
    model_retired = 0;
    checks++;
    if (obs() !== {z, z}) begin errors++; $display("FAIL %s reset_outputs: got %h want %h", tag, obs(), {z, z}); end
    checks++;
    if ({trap_cause, s_trap_cause, obs_cnt()} !== '0)
      begin errors++; $display("FAIL %s reset_regs: got cause %b retired %h want 0", tag, {trap_cause, s_trap_cause}, obs_cnt()); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (obs() !== {z, z}) begin errors++; $display("FAIL %s idle_hold: got %h want %h", tag, obs(), {z, z}); end
    run = 1'b1;
  endtask

  task automatic test_r_sub();
    bit tr;
    issue("r_sub", 7'b0110011, 7'b0100000, 3'b000, 0, 1'b1, tr);
  endtask

  task automatic test_load_wait();
    bit tr;
    issue("load_wait3", 7'b0000011, 7'h00, 3'b010, 3, 1'b0, tr);
  endtask

  task automatic test_store_fast();
    bit tr;
    issue("store_fast", 7'b0100011, 7'h00, 3'b010, 0, 1'b0, tr);
  endtask

  task automatic test_illegal();
    bit tr;
    issue("illegal_op", 7'b1111111, 7'h00, 3'b000, 0, 1'b0, tr);
    test_reset("after_illegal_op");
    issue("illegal_f7", 7'b0110011, 7'b0000001, 3'b000, 0, 1'b0, tr);
    test_reset("after_illegal_f7");
    issue("illegal_alt_f3", 7'b0010011, 7'b0100000, 3'b001, 0, 1'b0, tr);
    test_reset("after_illegal_alt");
  endtask

  task automatic test_timeout();
    bit tr;
    issue("store_timeout", 7'b0100011, 7'h00, 3'b010, 15, 1'b0, tr);
    test_reset("after_timeout");
    issue("store_ready_last", 7'b0100011, 7'h00, 3'b010, 14, 1'b0, tr);
    issue("load_ready_last", 7'b0000011, 7'h00, 3'b000, 14, 1'b1, tr);
  endtask

  task automatic test_run_drop();
    bit tr;
    issue("i_sra_drop", 7'b0010011, 7'b0100000, 3'b101, 0, 1'b1, tr);
    issue("store_drop", 7'b0100011, 7'h00, 3'b000, 2, 1'b1, tr);
  endtask

  task automatic test_async_reset();
    logic [12:0] e, z;
    z = '0;
    @(negedge clk); opcode = 7'b0000011; funct7 = 7'h00; funct3 = 3'b010; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    e = mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 4'd2);
    checks++;
    if (obs() !== {e, e}) begin errors++; $display("FAIL async_pre: got %h want %h", obs(), {e, e}); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({obs(), obs_cnt(), trap_cause} !== '0)
      begin errors++; $display("FAIL async_reset: got %h %h want 0", obs(), obs_cnt()); end
    test_reset("after_async");
  endtask

  task automatic test_random();
    bit tr, drop;
    int r, wn;
    logic [6:0] op, f7;
    logic [2:0] f3;
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: op = 7'b0110011;
        3, 4, 5: op = 7'b0010011;
        6, 7:    op = 7'b0000011;
        8:       op = 7'b0100011;
        default: op = 7'($urandom);
      endcase
      f3 = 3'($urandom);
      r = $urandom_range(0, 9);
      f7 = (r < 6) ? 7'h00 : (r < 9) ? 7'h20 : 7'($urandom);
      wn = ($urandom_range(0, 15) == 0) ? $urandom_range(13, 15) : $urandom_range(0, 3);
      drop = ($urandom_range(0, 7) == 0);
      issue("random", op, f7, f3, wn, drop, tr);
      if (tr) test_reset("random_recover");
    end
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; mem_ready = 1'b0;
    opcode = '0; funct7 = '0; funct3 = '0;
    test_reset("por");
    test_r_sub();
    test_load_wait();
    test_store_fast();
    test_illegal();
    test_timeout();
    test_run_drop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
